// File: rtl/var_delay_pkg.sv
// Shared constants and helpers for the variable delay line.
//   DEFAULT_DATAWIDTH / DEFAULT_CHANNELS / DEFAULT_MAX_DELAY : default parameter values
//   delay_width()     : width of the delay/occupancy fields, clog2(max_delay+1)
package var_delay_pkg;

  localparam int unsigned DEFAULT_DATAWIDTH = 32;
  localparam int unsigned DEFAULT_CHANNELS  = 1;
  localparam int unsigned DEFAULT_MAX_DELAY = 16;

  function automatic int unsigned delay_width(input int unsigned max_delay);
    return $clog2(max_delay + 1);
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One pipeline stage of the delay line: a data register plus a valid bit.
//   clk, rst        : clock, asynchronous active-high reset
//   en              : advance; when low the stage holds
//   clear           : drops the valid bit regardless of en (data still follows en)
//   d_data, d_valid : value from the previous stage
//   q_data, q_valid : registered stage contents
module delay_stage
  import var_delay_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_DATAWIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data  <= '0;
      q_valid <= 1'b0;
    end else begin
      if (en) q_data <= d_data;
      if (clear) begin
        q_valid <= 1'b0;
      end else if (en) begin
        q_valid <= d_valid;
      end
    end
  end

endmodule

// File: rtl/var_delay_line.sv
// Programmable-latency delay line: MAX_DELAY stages, output tapped at stage cur_delay-1.
//   clk, rst         : clock, asynchronous active-high reset
//   en               : advance enable (0 stalls every stage)
//   flush            : clears all in-flight valids, including the incoming sample
//   delay_load       : loads min(delay_sel, MAX_DELAY) into cur_delay, clears valids, no shift
//   delay_sel        : requested delay
//   in_valid, in     : input sample (CHANNELS packed lanes, lane 0 in the LSBs)
//   out_valid, out   : delayed sample; delay 0 is a combinational pass-through
//   cur_delay        : active delay
//   occupancy        : valid samples held in stages 0..cur_delay-1
//   cfg_err          : one-cycle pulse after loading an out-of-range delay
module var_delay_line
  import var_delay_pkg::*;
#(
  parameter  int unsigned DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter  int unsigned CHANNELS  = DEFAULT_CHANNELS,
  parameter  int unsigned MAX_DELAY = DEFAULT_MAX_DELAY,
  localparam int unsigned DW        = delay_width(MAX_DELAY),
  localparam int unsigned W         = CHANNELS * DATAWIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic          delay_load,
  input  logic [DW-1:0] delay_sel,
  input  logic          in_valid,
  input  logic [W-1:0]  in,
  output logic          out_valid,
  output logic [W-1:0]  out,
  output logic [DW-1:0] cur_delay,
  output logic [DW-1:0] occupancy,
  output logic          cfg_err
);

  localparam logic [DW-1:0] MAX_DELAY_W = DW'(MAX_DELAY);

  logic          stage_en;
  logic          stage_clear;
  logic          sel_over;
  logic [DW-1:0] sel_clamped;
  logic [DW-1:0] cur_delay_q;
  logic [DW-1:0] occ_q;
  logic [DW-1:0] occ_d;
  logic          cfg_err_q;

  // Index 0 is the block input; index i+1 is the output of stage i.
  logic [W-1:0]       chain_data [MAX_DELAY+1];
  logic [MAX_DELAY:0] chain_valid;
  logic [MAX_DELAY-1:0] valid_next;

  // A load both freezes the pipe and invalidates it so the new tap never sees stale samples.
  assign stage_en    = en & ~delay_load;
  assign stage_clear = flush | delay_load;

  assign chain_data[0]  = in;
  assign chain_valid[0] = in_valid;

  for (genvar g = 0; g < MAX_DELAY; g++) begin : g_stage
    delay_stage #(
      .WIDTH(W)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (stage_en),
      .clear  (stage_clear),
      .d_data (chain_data[g]),
      .d_valid(chain_valid[g]),
      .q_data (chain_data[g+1]),
      .q_valid(chain_valid[g+1])
    );
  end

  assign sel_over    = delay_sel > MAX_DELAY_W;
  assign sel_clamped = sel_over ? MAX_DELAY_W : delay_sel;

  // Occupancy is registered, so count the valid bits the stages will hold after this edge.
  // A load clears every valid, so the old cur_delay is correct whenever the count is non-zero.
  always_comb begin
    valid_next = stage_en ? chain_valid[MAX_DELAY-1:0] : chain_valid[MAX_DELAY:1];
    if (stage_clear) valid_next = '0;
    occ_d = '0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (i < int'(cur_delay_q) && valid_next[i]) occ_d = occ_d + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_delay_q <= MAX_DELAY_W;
      occ_q       <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      if (delay_load) cur_delay_q <= sel_clamped;
      occ_q     <= occ_d;
      cfg_err_q <= delay_load & sel_over;
    end
  end

  // Output tap; delay 0 falls through to the input unregistered.
  always_comb begin
    out       = in;
    out_valid = in_valid;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (cur_delay_q == DW'(i + 1)) begin
        out       = chain_data[i+1];
        out_valid = chain_valid[i+1];
      end
    end
  end

  assign cur_delay = cur_delay_q;
  assign occupancy = occ_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_var_delay_line.sv
// Self-checking bench for var_delay_line: a scoreboard queue holds expected samples tagged with
// the enabled-edge count at which they must appear; a negedge monitor pops and compares.
module tb_var_delay_line;

  localparam int unsigned DW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: defaults (32-bit, 1 lane, MAX_DELAY 16)
  logic          rst;
  logic          en;
  logic          flush;
  logic          delay_load;
  logic [DW-1:0] delay_sel;
  logic          in_valid;
  logic [31:0]   din;
  logic          out_valid;
  logic [31:0]   dout;
  logic [DW-1:0] cur_delay;
  logic [DW-1:0] occupancy;
  logic          cfg_err;

  // Second DUT: 2 lanes of 8 bits for the pass-through case
  logic          en2;
  logic          flush2;
  logic          load2;
  logic [DW-1:0] sel2;
  logic          in_valid2;
  logic [15:0]   din2;
  logic          out_valid2;
  logic [15:0]   dout2;
  logic [DW-1:0] cur_delay2;
  logic [DW-1:0] occupancy2;
  logic          cfg_err2;

  var_delay_line dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .delay_load(delay_load),
    .delay_sel (delay_sel),
    .in_valid  (in_valid),
    .in        (din),
    .out_valid (out_valid),
    .out       (dout),
    .cur_delay (cur_delay),
    .occupancy (occupancy),
    .cfg_err   (cfg_err)
  );

  var_delay_line #(
    .DATAWIDTH(8),
    .CHANNELS (2),
    .MAX_DELAY(16)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .en        (en2),
    .flush     (flush2),
    .delay_load(load2),
    .delay_sel (sel2),
    .in_valid  (in_valid2),
    .in        (din2),
    .out_valid (out_valid2),
    .out       (dout2),
    .cur_delay (cur_delay2),
    .occupancy (occupancy2),
    .cfg_err   (cfg_err2)
  );

  int          tests = 0;
  int          fails = 0;
  int unsigned en_edges = 0;
  int unsigned model_delay = 16;
  logic [31:0] exp_data[$];
  int unsigned exp_due[$];

  // Count edges that actually shift the pipe.
  always @(posedge clk) begin
    if (!rst && en && !delay_load) en_edges <= en_edges + 1;
  end

  // Monitor: a valid output is consumed when the coming edge shifts it out.
  always @(negedge clk) begin
    if (!rst && en && !delay_load && out_valid) begin
      tests++;
      if (exp_data.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got %0h at enabled edge %0d, required no valid output",
                 dout, en_edges);
      end else begin
        logic [31:0] d;
        int unsigned due;
        d   = exp_data.pop_front();
        due = exp_due.pop_front();
        if (dout !== d || en_edges != due) begin
          fails++;
          $display("FAIL scoreboard_out: got %0h at enabled edge %0d, required %0h at edge %0d",
                   dout, en_edges, d, due);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample driven now is accepted at edge en_edges+1 and shown after edge en_edges+model_delay.
  task automatic push(input logic [31:0] d);
    exp_data.push_back(d);
    exp_due.push_back(en_edges + model_delay);
  endtask

  task automatic load(input int unsigned d);
    delay_load = 1'b1;
    delay_sel  = DW'(d);
    step();
    delay_load  = 1'b0;
    model_delay = (d > 16) ? 16 : d;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; delay_load = 1'b0; delay_sel = '0;
    in_valid = 1'b0; din = '0;
    en2 = 1'b0; flush2 = 1'b0; load2 = 1'b0; sel2 = '0; in_valid2 = 1'b0; din2 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cur_delay", 64'(cur_delay), 64'd16);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(dout), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    rst = 1'b0;

    // Delay 0 on the 2-lane instance: combinational pass-through with en low
    load2 = 1'b1; sel2 = '0;
    step();
    load2 = 1'b0;
    chk("d0_cur_delay", 64'(cur_delay2), 64'd0);
    chk("d0_cfg_err", 64'(cfg_err2), 64'd0);
    din2 = 16'h1234; in_valid2 = 1'b1;
    #1;
    chk("d0_out_a", 64'(dout2), 64'h1234);
    chk("d0_valid_a", 64'(out_valid2), 64'd1);
    din2 = 16'hABCD; in_valid2 = 1'b0;
    #1;
    chk("d0_out_b", 64'(dout2), 64'hABCD);
    chk("d0_valid_b", 64'(out_valid2), 64'd0);
    chk("d0_occupancy", 64'(occupancy2), 64'd0);

    // Delay 4 streaming 1..10
    load(4);
    chk("l4_cur_delay", 64'(cur_delay), 64'd4);
    chk("l4_cfg_err", 64'(cfg_err), 64'd0);
    for (int i = 1; i <= 10; i++) begin
      din = 32'(i); in_valid = 1'b1; en = 1'b1;
      push(32'(i));
      step();
      if (i == 8) chk("l4_occupancy_steady", 64'(occupancy), 64'd4);
    end
    in_valid = 1'b0;
    repeat (6) step();
    chk("l4_occupancy_drained", 64'(occupancy), 64'd0);
    chk("l4_queue_empty", 64'(exp_data.size()), 64'd0);

    // Delay 3 with a 5-cycle stall after accept
    load(3);
    din = 32'hA5; in_valid = 1'b1; en = 1'b1;
    push(32'hA5);
    step();
    in_valid = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_out_valid", 64'(out_valid), 64'd0);
    end
    chk("stall_occupancy", 64'(occupancy), 64'd1);
    en = 1'b1;
    step();
    chk("stall_not_yet", 64'(out_valid), 64'd0);
    step();
    chk("stall_out_valid_edge8", 64'(out_valid), 64'd1);
    chk("stall_out_edge8", 64'(dout), 64'hA5);
    repeat (2) step();

    // Delay 5, three samples in flight, then flush (incoming sample discarded too)
    load(5);
    for (int i = 1; i <= 3; i++) begin
      din = 32'(i * 32'h11); in_valid = 1'b1;
      step();
    end
    chk("fl_occupancy_pre", 64'(occupancy), 64'd3);
    flush = 1'b1; din = 32'h44; in_valid = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_occupancy", 64'(occupancy), 64'd0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fl_quiet", 64'(out_valid), 64'd0);
    end
    din = 32'h55; in_valid = 1'b1; push(32'h55); step();
    din = 32'h66; push(32'h66); step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("fl_occupancy_drained", 64'(occupancy), 64'd0);

    // Out-of-range load clamps to 16, pulses cfg_err, drops the in-flight sample
    din = 32'h77; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    load(20);
    chk("clamp_cur_delay", 64'(cur_delay), 64'd16);
    chk("clamp_cfg_err_pulse", 64'(cfg_err), 64'd1);
    chk("clamp_occupancy", 64'(occupancy), 64'd0);
    step();
    chk("clamp_cfg_err_clear", 64'(cfg_err), 64'd0);
    repeat (17) step();
    din = 32'h88; in_valid = 1'b1; push(32'h88); step();
    din = 32'h99; push(32'h99); step();
    in_valid = 1'b0;
    repeat (17) step();
    chk("clamp_queue_empty", 64'(exp_data.size()), 64'd0);

    // Asynchronous reset mid-stream
    load(2);
    din = 32'h71; in_valid = 1'b1; push(32'h71); step();
    din = 32'h72; push(32'h72); step();
    din = 32'h73; push(32'h73); step();
    in_valid = 1'b0;
    chk("ar_out_valid_pre", 64'(out_valid), 64'd1);
    chk("ar_out_pre", 64'(dout), 64'h72);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_out", 64'(dout), 64'd0);
    chk("ar_cur_delay", 64'(cur_delay), 64'd16);
    chk("ar_occupancy", 64'(occupancy), 64'd0);
    exp_data.delete();
    exp_due.delete();
    model_delay = 16;
    step();
    rst = 1'b0;
    din = 32'h80; in_valid = 1'b1; push(32'h80); step();
    in_valid = 1'b0;
    repeat (18) step();
    chk("final_queue_empty", 64'(exp_data.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
